// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one SDRAM memory_controller between the VDP, an auxiliary port and refresh.
// Define VRAM_ARBITER_AUX_EN to enable the auxiliary port; otherwise it is tied off.
module vram_arbiter #(
  parameter int REFRESH_INTERVAL = 840,
  parameter int AUX_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vdp_req,
  input  logic        vdp_wr,
  input  logic [16:0] vdp_addr,
  input  logic [7:0]  vdp_din,
  output logic [15:0] vdp_dout,
  output logic        vdp_ack,
  input  logic        aux_req,
  input  logic        aux_wr,
  input  logic [16:0] aux_addr,
  input  logic [7:0]  aux_din,
  output logic [15:0] aux_dout,
  output logic        aux_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wdm,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  input  logic        mem_enabled
);

  typedef enum logic [2:0] {IDLE, CMD, WAIT_HI, WAIT_LO, DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_VDP, G_AUX, G_REF} grant_t;

  localparam int RW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [RW-1:0] REF_FULL = RW'(REFRESH_INTERVAL);
  localparam logic [RW-1:0] REF_HALF = RW'(REFRESH_INTERVAL / 2);
  localparam logic [RW-1:0] REF_ONE  = RW'(1);

  state_t        state_r, state_nx;
  grant_t        grant_r, grant_sel;
  logic          wr_r;
  logic [RW-1:0] ref_cnt_r;
  logic          aux_live, aux_starved;
  logic          launch, finish, port_sel, sel_wr;
  logic [16:0]   sel_addr;
  logic [7:0]    sel_din;

  assign launch   = (state_r == IDLE) && (state_nx == CMD);
  assign finish   = (state_r == WAIT_LO) && !mem_busy;
  assign port_sel = (grant_sel == G_VDP) || (grant_sel == G_AUX);
  assign sel_wr   = (grant_sel == G_AUX) ? aux_wr   : vdp_wr;
  assign sel_addr = (grant_sel == G_AUX) ? aux_addr : vdp_addr;
  assign sel_din  = (grant_sel == G_AUX) ? aux_din  : vdp_din;

  // Priority grant; only acted on when the FSM leaves IDLE.
  always_comb begin
    grant_sel = G_NONE;
    if (ref_cnt_r >= REF_FULL) begin
      grant_sel = G_REF;
    end else if (aux_starved) begin
      grant_sel = G_AUX;
    end else if (vdp_req) begin
      grant_sel = G_VDP;
    end else if (aux_live) begin
      grant_sel = G_AUX;
    end else if (ref_cnt_r >= REF_HALF) begin
      grant_sel = G_REF;
    end else begin
      grant_sel = G_NONE;
    end
  end

  // Next-state logic; WAIT_HI trusts the controller to raise busy after every strobe.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (mem_enabled && !mem_busy && (grant_sel != G_NONE)) state_nx = CMD;
        else state_nx = IDLE;
      end
      CMD: state_nx = WAIT_HI;
      WAIT_HI: begin
        if (mem_busy) state_nx = WAIT_LO;
        else state_nx = WAIT_HI;
      end
      WAIT_LO: begin
        if (!mem_busy) state_nx = DONE;
        else state_nx = WAIT_LO;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latched request, command strobes and VDP completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      grant_r     <= G_NONE;
      wr_r        <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_refresh <= 1'b0;
      mem_addr    <= 22'h000000;
      mem_din     <= 16'h0000;
      mem_wdm     <= 2'b00;
      vdp_ack     <= 1'b0;
      vdp_dout    <= 16'h0000;
    end else begin
      state_r     <= state_nx;
      mem_read    <= launch && port_sel && !sel_wr;
      mem_write   <= launch && port_sel && sel_wr;
      mem_refresh <= launch && (grant_sel == G_REF);
      if (launch) begin
        grant_r  <= grant_sel;
        wr_r     <= sel_wr;
        mem_addr <= {6'b000000, sel_addr[16:1]};
        mem_din  <= {sel_din, sel_din};
        mem_wdm  <= {~sel_addr[0], sel_addr[0]};
      end
      vdp_ack <= finish && (grant_r == G_VDP);
      if (finish && (grant_r == G_VDP) && !wr_r) vdp_dout <= mem_dout;
    end
  end

  // Refresh age counter, held at zero until the controller is initialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt_r <= {RW{1'b0}};
    end else if (!mem_enabled || (launch && (grant_sel == G_REF))) begin
      ref_cnt_r <= {RW{1'b0}};
    end else if (ref_cnt_r < REF_FULL) begin
      ref_cnt_r <= ref_cnt_r + REF_ONE;
    end
  end

`ifdef VRAM_ARBITER_AUX_EN
  localparam int SW = $clog2(AUX_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(AUX_STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic [SW-1:0] starve_r;

  assign aux_live    = aux_req;
  assign aux_starved = aux_req && (starve_r == STARVE_MAX);

  // Counts VDP grants that overtook a waiting aux request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_r <= {SW{1'b0}};
    end else if (!aux_req || (launch && (grant_sel == G_AUX))) begin
      starve_r <= {SW{1'b0}};
    end else if (launch && (grant_sel == G_VDP) && (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + STARVE_ONE;
    end
  end

  // Aux completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aux_ack  <= 1'b0;
      aux_dout <= 16'h0000;
    end else begin
      aux_ack <= finish && (grant_r == G_AUX);
      if (finish && (grant_r == G_AUX) && !wr_r) aux_dout <= mem_dout;
    end
  end
`else
  logic unused_aux_req;

  assign aux_live       = 1'b0;
  assign aux_starved    = 1'b0;
  assign aux_ack        = 1'b0;
  assign aux_dout       = 16'h0000;
  assign unused_aux_req = aux_req;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a simple busy-handshake controller model.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        vdp_req, vdp_wr, aux_req, aux_wr;
  logic [16:0] vdp_addr, aux_addr;
  logic [7:0]  vdp_din, aux_din;
  logic [15:0] vdp_dout, aux_dout, mem_din, mem_dout;
  logic        vdp_ack, aux_ack;
  logic        mem_read, mem_write, mem_refresh, mem_busy, mem_enabled;
  logic [21:0] mem_addr;
  logic [1:0]  mem_wdm;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, busy_len = 3, busy_cnt = 0;
  int n_read, n_write, n_refresh, n_vdp_ack, n_aux_ack, n_multi = 0;
  int last_ref, max_gap;
  int ack_log[$];
  logic [21:0] cap_addr;
  logic [15:0] cap_din;
  logic [1:0]  cap_wdm;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .vdp_req(vdp_req), .vdp_wr(vdp_wr), .vdp_addr(vdp_addr), .vdp_din(vdp_din),
    .vdp_dout(vdp_dout), .vdp_ack(vdp_ack),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_din(aux_din),
    .aux_dout(aux_dout), .aux_ack(aux_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wdm(mem_wdm), .mem_dout(mem_dout),
    .mem_busy(mem_busy), .mem_enabled(mem_enabled)
  );

  always #5 clk = ~clk;

  // Controller model: raises busy after a strobe and drops it busy_len cycles later.
  initial begin
    mem_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        mem_busy = 1'b0;
        busy_cnt = 0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) mem_busy = 1'b0;
        end
        if (mem_read || mem_write || mem_refresh) begin
          mem_busy = 1'b1;
          busy_cnt = busy_len;
          cap_addr = mem_addr;
          cap_din  = mem_din;
          cap_wdm  = mem_wdm;
        end
      end
      if (mem_read) n_read++;
      if (mem_write) n_write++;
      if (int'(mem_read) + int'(mem_write) + int'(mem_refresh) > 1) n_multi++;
      if (mem_refresh) begin
        n_refresh++;
        if (cyc - last_ref > max_gap) max_gap = cyc - last_ref;
        last_ref = cyc;
      end
      if (vdp_ack) begin n_vdp_ack++; ack_log.push_back(1); end
      if (aux_ack) begin n_aux_ack++; ack_log.push_back(2); end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_read = 0; n_write = 0; n_refresh = 0; n_vdp_ack = 0; n_aux_ack = 0;
    ack_log.delete();
  endtask

  task automatic vdp_txn(input logic wr, input logic [16:0] addr, input logic [7:0] din,
                         output logic got_ack);
    @(negedge clk);
    vdp_wr = wr; vdp_addr = addr; vdp_din = din; vdp_req = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vdp_ack) begin got_ack = 1'b1; break; end
    end
    vdp_req = 1'b0;
  endtask

  initial begin
    logic ok;
    int   t0;
    reset = 1'b1; mem_enabled = 1'b1; mem_dout = 16'h0000;
    vdp_req = 1'b0; vdp_wr = 1'b0; vdp_addr = 17'h00000; vdp_din = 8'h00;
    aux_req = 1'b0; aux_wr = 1'b0; aux_addr = 17'h00000; aux_din = 8'h00;
    last_ref = 0; max_gap = 0;
    clr_counts();
    repeat (2) @(negedge clk);
    check_eq("rst_strobes", {29'd0, mem_read, mem_write, mem_refresh}, 32'd0);
    check_eq("rst_acks", {30'd0, vdp_ack, aux_ack}, 32'd0);
    check_eq("rst_vdp_dout", {16'd0, vdp_dout}, 32'd0);
    check_eq("rst_aux_dout", {16'd0, aux_dout}, 32'd0);

    // Idle after reset: opportunistic refresh near REFRESH_INTERVAL/2.
    reset = 1'b0;
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (mem_refresh) begin ok = 1'b1; break; end
    end
    check_eq("first_ref_seen", {31'd0, ok}, 32'd1);
    check_eq("first_ref_window", {31'd0, ((cyc - t0) >= 418) && ((cyc - t0) <= 424)}, 32'd1);
    repeat (8) @(negedge clk);

    // Read at odd byte address.
    clr_counts();
    mem_dout = 16'hA55A;
    vdp_txn(1'b0, 17'h00003, 8'h00, ok);
    check_eq("rd_ack_seen", {31'd0, ok}, 32'd1);
    check_eq("rd_dout", {16'd0, vdp_dout}, 32'h0000A55A);
    repeat (5) @(negedge clk);
    check_eq("rd_n_read", n_read, 32'd1);
    check_eq("rd_n_write", n_write, 32'd0);
    check_eq("rd_addr", {10'd0, cap_addr}, 32'h00000001);
    check_eq("rd_n_ack", n_vdp_ack, 32'd1);

    // Write to even address: dout must keep the previous read data.
    clr_counts();
    mem_dout = 16'h1111;
    vdp_txn(1'b1, 17'h00010, 8'h3C, ok);
    check_eq("wr_ack_seen", {31'd0, ok}, 32'd1);
    check_eq("wr_dout_kept", {16'd0, vdp_dout}, 32'h0000A55A);
    repeat (5) @(negedge clk);
    check_eq("wr_n_write", n_write, 32'd1);
    check_eq("wr_n_read", n_read, 32'd0);
    check_eq("wr_din", {16'd0, cap_din}, 32'h00003C3C);
    check_eq("wr_wdm", {30'd0, cap_wdm}, 32'd2);
    check_eq("wr_addr", {10'd0, cap_addr}, 32'h00000008);
    check_eq("wr_n_ack", n_vdp_ack, 32'd1);

    // Write to the top odd address.
    clr_counts();
    vdp_txn(1'b1, 17'h1FFFF, 8'hC5, ok);
    check_eq("wr_hi_ack_seen", {31'd0, ok}, 32'd1);
    repeat (5) @(negedge clk);
    check_eq("wr_hi_addr", {10'd0, cap_addr}, 32'h0000FFFF);
    check_eq("wr_hi_wdm", {30'd0, cap_wdm}, 32'd1);
    check_eq("wr_hi_din", {16'd0, cap_din}, 32'h0000C5C5);

    // Controller not enabled: request must wait, then complete.
    @(negedge clk);
    mem_enabled = 1'b0;
    clr_counts();
    mem_dout = 16'hBEEF;
    vdp_wr = 1'b0; vdp_addr = 17'h00100; vdp_req = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("dis_no_strobe", n_read + n_write + n_refresh, 32'd0);
    check_eq("dis_no_ack", n_vdp_ack, 32'd0);
    mem_enabled = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vdp_ack) begin ok = 1'b1; break; end
    end
    vdp_req = 1'b0;
    check_eq("en_ack_seen", {31'd0, ok}, 32'd1);
    check_eq("en_dout", {16'd0, vdp_dout}, 32'h0000BEEF);
    check_eq("en_addr", {10'd0, cap_addr}, 32'h00000080);
    repeat (5) @(negedge clk);

    // Reset while waiting for busy to fall.
    clr_counts();
    busy_len = 10;
    mem_dout = 16'h7777;
    vdp_wr = 1'b0; vdp_addr = 17'h00004; vdp_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_busy) begin ok = 1'b1; break; end
    end
    check_eq("wlo_busy_seen", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    vdp_req = 1'b0;
    #1;
    check_eq("wlo_rst_strobes", {29'd0, mem_read, mem_write, mem_refresh}, 32'd0);
    check_eq("wlo_rst_ack", {31'd0, vdp_ack}, 32'd0);
    check_eq("wlo_rst_dout", {16'd0, vdp_dout}, 32'd0);
    check_eq("wlo_rst_addr", {10'd0, mem_addr}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    busy_len = 3;
    repeat (12) @(negedge clk);
    check_eq("wlo_no_ack", n_vdp_ack, 32'd0);
    mem_dout = 16'h1234;
    vdp_txn(1'b0, 17'h00006, 8'h00, ok);
    check_eq("post_rst_ack_seen", {31'd0, ok}, 32'd1);
    check_eq("post_rst_dout", {16'd0, vdp_dout}, 32'h00001234);
    check_eq("post_rst_addr", {10'd0, cap_addr}, 32'h00000003);
    repeat (5) @(negedge clk);

    // Continuous VDP traffic must not starve refresh.
    clr_counts();
    max_gap = 0;
    last_ref = cyc;
    vdp_wr = 1'b0; vdp_addr = 17'h00020; vdp_req = 1'b1;
    repeat (2000) @(negedge clk);
    vdp_req = 1'b0;
    check_eq("ref_under_load", {31'd0, n_refresh >= 2}, 32'd1);
    check_eq("ref_max_gap", {31'd0, max_gap <= 860}, 32'd1);
    check_eq("vdp_throughput", {31'd0, n_vdp_ack > 200}, 32'd1);
    repeat (10) @(negedge clk);

    // Both requesters held.
    clr_counts();
    aux_wr = 1'b0; aux_addr = 17'h00040; vdp_req = 1'b1; aux_req = 1'b1;
    repeat (200) @(negedge clk);
    vdp_req = 1'b0; aux_req = 1'b0;
    repeat (10) @(negedge clk);
`ifdef VRAM_ARBITER_AUX_EN
    check_eq("aux_log_len", {31'd0, ack_log.size() >= 10}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < ack_log.size()) check_eq("aux_order", ack_log[i], ((i % 5) == 4) ? 32'd2 : 32'd1);
      else check_eq("aux_order", 32'd0, ((i % 5) == 4) ? 32'd2 : 32'd1);
    end
`else
    check_eq("aux_off_ack", n_aux_ack, 32'd0);
    check_eq("aux_off_dout", {16'd0, aux_dout}, 32'd0);
    check_eq("aux_off_vdp_served", {31'd0, n_vdp_ack > 10}, 32'd1);
`endif

    check_eq("one_strobe", n_multi, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
